// File: rtl/piso_pkg.sv
// Shared definitions for the piso parallel-in, serial-out shift register.
// Optional build macro: PISO_MSB_FIRST_EN (MSB-first bit order when defined).
package piso_pkg;

   localparam int PISO_DEFAULT_WIDTH = 4;

   // Width of a counter able to hold the values 0..width.
   function automatic int piso_cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

   // Frame phase as seen from the bit counter: nothing left means next enabled edge loads.
   typedef enum logic {
      PISO_LOAD  = 1'b0,
      PISO_SHIFT = 1'b1
   } piso_phase_e;

endpackage

// File: rtl/piso_if.sv
// Handshake/data bundle for piso: enable qualifier, parallel word in, serial bit out.
// Optional build macro: PISO_MSB_FIRST_EN (affects only bit order inside piso).
interface piso_if
   import piso_pkg::*;
#(
   parameter int WIDTH = PISO_DEFAULT_WIDTH
);

   logic             enable;
   logic [WIDTH-1:0] data;
   logic             out;

   modport master (output enable, output data, input out);
   modport slave  (input enable, input data, output out);

endinterface

// File: rtl/piso_bit_counter.sv
// Bit counter for piso: tracks how many bits of the current frame are still
// held in the shift register and raises the load strobe when a new word is due.
// Optional build macro: PISO_MSB_FIRST_EN (no effect on counting).
module piso_bit_counter
   import piso_pkg::*;
#(
   parameter int WIDTH = PISO_DEFAULT_WIDTH,
   localparam int CW   = piso_cnt_w(WIDTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   output logic [CW-1:0] cnt,
   output logic          load,
   output piso_phase_e   phase
);

   assign phase = (cnt == '0) ? PISO_LOAD : PISO_SHIFT;
   assign load  = enable && (phase == PISO_LOAD);

   // Reload to WIDTH-1 on a load edge, count down on shift edges, hold when disabled.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CW'(WIDTH - 1);
      end else if (enable) begin
         cnt <= cnt - 1'b1;
      end
   end

   // The counter never exceeds the number of bits left after a load.
   a_cnt_range : assert property (@(posedge clk) cnt <= CW'(WIDTH - 1));

endmodule

// File: rtl/piso.sv
// piso: parameterised parallel-in, serial-out shift register.
// A WIDTH-bit word is captured on a load edge and emitted one bit per enabled
// clock on a registered serial output; frames stream back-to-back while
// enable stays high. LSB first by default.
// Optional build macro: PISO_MSB_FIRST_EN (emit MSB first instead).
module piso
   import piso_pkg::*;
#(
   parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
   input  logic clk,
   input  logic reset,
   piso_if.slave bus
);

   localparam int CW = piso_cnt_w(WIDTH);

   logic [CW-1:0]    cnt;
   logic             load;
   piso_phase_e      phase;
   logic [WIDTH-1:0] shreg;
   logic             out_q;

   piso_bit_counter #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .enable (bus.enable),
      .cnt    (cnt),
      .load   (load),
      .phase  (phase)
   );

   assign bus.out = out_q;

   // Capture the word and present its first bit on load; shift with zero fill otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_q <= 1'b0;
         shreg <= '0;
      end else if (load) begin
`ifdef PISO_MSB_FIRST_EN
         out_q <= bus.data[WIDTH-1];
         shreg <= bus.data << 1;
`else
         out_q <= bus.data[0];
         shreg <= bus.data >> 1;
`endif
      end else if (bus.enable) begin
`ifdef PISO_MSB_FIRST_EN
         out_q <= shreg[WIDTH-1];
         shreg <= shreg << 1;
`else
         out_q <= shreg[0];
         shreg <= shreg >> 1;
`endif
      end
   end

   // A load can only happen when no bits of the previous frame remain.
   a_load_phase : assert property (@(posedge clk) load |-> phase == PISO_LOAD);

endmodule

// File: tb/tb_piso.sv
// Scoreboard testbench for piso: directed scenarios followed by random
// stimulus, checked against a queue-of-bits reference model.
module tb_piso;
   import piso_pkg::*;

   localparam int WIDTH = PISO_DEFAULT_WIDTH;

   typedef struct {
      string name;
      logic  out;
      int    cnt;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   piso_if #(.WIDTH(WIDTH)) bus ();

   piso #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   exp_t exp_q[$];
   int   pend[$];
   logic model_out = 1'b0;
   int   errors = 0;
   int   checks = 0;
   exp_t mon_e;

   // Reference: a frame is the list of its bits in transmit order; each enabled
   // edge sends the next bit, starting a fresh frame when the list is empty.
   task automatic model_edge(input logic r, input logic en, input logic [WIDTH-1:0] d);
      if (r) begin
         pend.delete();
         model_out = 1'b0;
      end else if (en) begin
         if (pend.size() == 0) begin
            for (int i = 0; i < WIDTH; i++) begin
`ifdef PISO_MSB_FIRST_EN
               pend.push_back(int'(d[WIDTH-1-i]));
`else
               pend.push_back(int'(d[i]));
`endif
            end
         end
         model_out = logic'(pend.pop_front());
      end
   endtask

   task automatic step(input logic r, input logic en, input logic [WIDTH-1:0] d, input string name);
      exp_t e;
      @(negedge clk);
      reset      = r;
      bus.enable = en;
      bus.data   = d;
      model_edge(r, en, d);
      e.name = name;
      e.out  = model_out;
      e.cnt  = pend.size();
      exp_q.push_back(e);
      @(posedge clk);
   endtask

   // Monitor: after each edge, compare DUT output and bit count with the oldest expectation.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (bus.out !== mon_e.out) begin
               errors++;
               $display("FAIL %s out: got %b expected %b at %0t", mon_e.name, bus.out, mon_e.out, $time);
            end
            checks++;
            if (int'(dut.u_cnt.cnt) != mon_e.cnt) begin
               errors++;
               $display("FAIL %s cnt: got %0d expected %0d at %0t", mon_e.name, dut.u_cnt.cnt, mon_e.cnt, $time);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.enable = 1'b0;
      bus.data   = '0;

      // Reset then two back-to-back frames.
      step(1'b1, 1'b1, 4'b1101, "reset");
      repeat (8) step(1'b0, 1'b1, 4'b1101, "stream");

      // Hold mid-frame.
      step(1'b0, 1'b1, 4'b0110, "hold_load");
      step(1'b0, 1'b1, 4'b0110, "hold_shift");
      repeat (3) step(1'b0, 1'b0, 4'b0110, "hold_idle");
      repeat (2) step(1'b0, 1'b1, 4'b0110, "hold_resume");
      step(1'b0, 1'b1, 4'b0110, "hold_reload");

      // Data change mid-frame.
      step(1'b1, 1'b0, 4'b0000, "dchg_reset");
      step(1'b0, 1'b1, 4'b1111, "dchg_load");
      repeat (3) step(1'b0, 1'b1, 4'b0000, "dchg_frame");
      repeat (4) step(1'b0, 1'b1, 4'b0000, "dchg_next");

      // Reset mid-frame.
      step(1'b0, 1'b1, 4'b1010, "rmid_load");
      step(1'b0, 1'b1, 4'b1010, "rmid_shift");
      step(1'b1, 1'b1, 4'b1010, "rmid_reset");
      repeat (4) step(1'b0, 1'b1, 4'b0011, "rmid_after");

      // Reset priority over enable.
      repeat (2) step(1'b1, 1'b1, 4'b1001, "rprio_hold");
      repeat (4) step(1'b0, 1'b1, 4'b1001, "rprio_load");

      // Randomized traffic with enable gaps and occasional resets.
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
              WIDTH'($urandom), "random");
      end

      // Let the monitor consume the last expectation.
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
